// File: rtl/clock_enable_gen.sv
// clock_enable_gen: per-channel phase-accumulator clock-enable generator.
// Each channel adds its increment to an accumulator every cycle and emits a
// one-cycle cen pulse after every accumulator overflow. Increments are
// retuned through a shadow register so a new rate takes effect only at an
// overflow, which keeps the pulse train free of short or doubled periods.
// Optional feature: define CEN_SYNC_EN to add the sync_req port, which
// realigns all accumulators to zero.
module clock_enable_gen #(
    parameter  int CHANNELS    = 4,
    parameter  int ACC_WIDTH   = 32,
    parameter  int LOCK_CYCLES = 1024,
    localparam int AW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Write port: a single-cycle strobe. Each cycle with wr_en=1 is one
    // write of wr_data into the shadow of channel wr_addr; there is no
    // back-pressure, and addresses with no matching channel are dropped.
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [ACC_WIDTH-1:0] wr_data,
`ifdef CEN_SYNC_EN
    input  logic                 sync_req,
`endif
    output logic [CHANNELS-1:0]  cen,
    output logic [CHANNELS-1:0]  pending,
    output logic                 ready
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [1:0]    rst_sync;
    logic          run;
    logic [LW-1:0] lock_cnt;
    logic          ready_q;
    logic          sync_clr;

`ifdef CEN_SYNC_EN
    assign sync_clr = sync_req;
`else
    assign sync_clr = 1'b0;
`endif

    // Reset asserts immediately but releases only after two clock edges,
    // so no register leaves reset on an edge close to the rst_n rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Lock counter: counts up from zero once running, saturates at
    // LOCK_CYCLES and latches ready on the edge it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            ready_q  <= 1'b0;
        end else if (!run) begin
            lock_cnt <= '0;
            ready_q  <= 1'b0;
        end else if (lock_cnt != LW'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] inc;
        logic [ACC_WIDTH-1:0] sh;
        logic                 pend_q;
        logic                 cen_q;
        logic [ACC_WIDTH:0]   sum;
        logic                 carry;
        logic                 wr_hit;
        logic                 xfer;

        // Next-state terms: overflow of the add (masked on a realign), a
        // write addressed here, and the shadow-to-active transfer, which
        // fires on overflow or at once if the channel is stopped.
        always_comb begin
            sum    = {1'b0, acc} + {1'b0, inc};
            carry  = sum[ACC_WIDTH] & ~sync_clr;
            wr_hit = wr_en && (wr_addr == AW'(i));
            xfer   = pend_q && (carry || (inc == '0));
        end

        // Channel state: accumulator, active/shadow increments, pending
        // flag and the registered enable pulse. A write in the same cycle
        // as a transfer keeps pending set for the newer value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc    <= '0;
                inc    <= '0;
                sh     <= '0;
                pend_q <= 1'b0;
                cen_q  <= 1'b0;
            end else if (!run) begin
                acc    <= '0;
                inc    <= '0;
                sh     <= '0;
                pend_q <= 1'b0;
                cen_q  <= 1'b0;
            end else begin
                acc   <= sync_clr ? '0 : sum[ACC_WIDTH-1:0];
                cen_q <= carry & ready_q;
                if (xfer) begin
                    inc <= sh;
                end
                if (wr_hit) begin
                    sh     <= wr_data;
                    pend_q <= 1'b1;
                end else if (xfer) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign cen[i]     = cen_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: bench for clock_enable_gen with 3 channels, 8-bit
// accumulators and a 4-cycle lock. Expected outputs are hand-derived;
// ready rises 6 edges after rst_n release (2 synchroniser edges plus 4
// lock cycles).
module tb_clock_enable_gen;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int OW = 2 * CH + 1;

    // Output vector layout {cen[2:0], pending[2:0], ready}
    localparam logic [OW-1:0] M_ALL   = 7'b111_1111;
    localparam logic [OW-1:0] M_CH0   = 7'b001_0010;
    localparam logic [OW-1:0] M_CH2   = 7'b100_1110;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          sync_req;
    logic [CH-1:0] cen;
    logic [CH-1:0] pending;
    logic          ready;

    int checks   = 0;
    int failures = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] mask_q[$];
    int            id_q[$];

    typedef struct {
        logic          en;
        logic [1:0]    addr;
        logic [W-1:0]  data;
        logic [CH-1:0] cen;
        logic [CH-1:0] pend;
        logic          rdy;
    } vec_t;

    vec_t tbl[24];

    clock_enable_gen #(
        .CHANNELS   (CH),
        .ACC_WIDTH  (W),
        .LOCK_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef CEN_SYNC_EN
        .sync_req(sync_req),
`endif
        .cen     (cen),
        .pending (pending),
        .ready   (ready)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pk(input logic [CH-1:0] c, input logic [CH-1:0] p,
                                         input logic r);
        return {c, p, r};
    endfunction

    function automatic vec_t mk(input logic en, input logic [1:0] a, input logic [W-1:0] d,
                                input logic [CH-1:0] c, input logic [CH-1:0] p, input logic r);
        vec_t v;
        v.en = en; v.addr = a; v.data = d; v.cen = c; v.pend = p; v.rdy = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Driver: called at a negedge; drives one cycle of inputs, records the
    // outputs expected after the coming posedge, then waits a full cycle.
    task automatic step(input int id, input logic en, input logic [1:0] a,
                        input logic [W-1:0] d, input logic s,
                        input logic [OW-1:0] e, input logic [OW-1:0] m);
        wr_en    = en;
        wr_addr  = a;
        wr_data  = d;
        sync_req = s;
        exp_q.push_back(e);
        mask_q.push_back(m);
        id_q.push_back(id);
        @(negedge clk);
    endtask

    task automatic idle(input int id, input logic [OW-1:0] e, input logic [OW-1:0] m);
        step(id, 1'b0, 2'd0, 8'd0, 1'b0, e, m);
    endtask

    // Scoreboard: one expectation is consumed per clock, 1 time unit after
    // the rising edge.
    logic [OW-1:0] sb_e;
    logic [OW-1:0] sb_m;
    logic [OW-1:0] sb_a;
    int            sb_id;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            sb_e  = exp_q.pop_front();
            sb_m  = mask_q.pop_front();
            sb_id = id_q.pop_front();
            sb_a  = {cen, pending, ready};
            checks++;
            if ((sb_a & sb_m) !== (sb_e & sb_m)) begin
                failures++;
                $display("FAIL step_%0d: got cen=%b pending=%b ready=%b expected %b mask %b",
                         sb_id, cen, pending, ready, sb_e, sb_m);
            end
        end
    end

    initial begin
        // Lock-up, two channels started, one out-of-range write
        tbl[0]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b0);
        tbl[1]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b0);
        tbl[2]  = mk(1'b1, 2'd0, 8'd64,  3'b000, 3'b001, 1'b0);
        tbl[3]  = mk(1'b1, 2'd1, 8'd96,  3'b000, 3'b010, 1'b0);
        tbl[4]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b0);
        tbl[5]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[6]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[7]  = mk(1'b0, 2'd0, 8'd0,   3'b011, 3'b000, 1'b1);
        tbl[8]  = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[9]  = mk(1'b1, 2'd3, 8'd200, 3'b000, 3'b000, 1'b1);
        tbl[10] = mk(1'b0, 2'd0, 8'd0,   3'b010, 3'b000, 1'b1);
        tbl[11] = mk(1'b0, 2'd0, 8'd0,   3'b001, 3'b000, 1'b1);
        tbl[12] = mk(1'b0, 2'd0, 8'd0,   3'b010, 3'b000, 1'b1);
        tbl[13] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[14] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[15] = mk(1'b0, 2'd0, 8'd0,   3'b011, 3'b000, 1'b1);
        tbl[16] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[17] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[18] = mk(1'b0, 2'd0, 8'd0,   3'b010, 3'b000, 1'b1);
        tbl[19] = mk(1'b0, 2'd0, 8'd0,   3'b001, 3'b000, 1'b1);
        tbl[20] = mk(1'b0, 2'd0, 8'd0,   3'b010, 3'b000, 1'b1);
        tbl[21] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[22] = mk(1'b0, 2'd0, 8'd0,   3'b000, 3'b000, 1'b1);
        tbl[23] = mk(1'b0, 2'd0, 8'd0,   3'b011, 3'b000, 1'b1);

        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = '0;
        sync_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cen",     OW'(cen),     OW'(0));
        chk("reset_pending", OW'(pending), OW'(0));
        chk("reset_ready",   OW'(ready),   OW'(0));
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            step(k + 1, tbl[k].en, tbl[k].addr, tbl[k].data, 1'b0,
                 pk(tbl[k].cen, tbl[k].pend, tbl[k].rdy), M_ALL);
        end

        // Retune ch0 64 -> 128 mid-period: switch lands on the next carry
        idle(25, pk(3'b000, 3'b000, 1'b1), M_CH0);
        step(26, 1'b1, 2'd0, 8'd128, 1'b0, pk(3'b000, 3'b001, 1'b1), M_CH0);
        idle(27, pk(3'b000, 3'b001, 1'b1), M_CH0);
        idle(28, pk(3'b001, 3'b000, 1'b1), M_CH0);
        idle(29, pk(3'b000, 3'b000, 1'b1), M_CH0);
        idle(30, pk(3'b001, 3'b000, 1'b1), M_CH0);
        idle(31, pk(3'b000, 3'b000, 1'b1), M_CH0);
        idle(32, pk(3'b001, 3'b000, 1'b1), M_CH0);

        // ch2: start from stopped, then two writes before a carry plus an
        // out-of-range write; only the last value (16) takes effect
        step(33, 1'b1, 2'd2, 8'd64, 1'b0, pk(3'b000, 3'b100, 1'b1), M_CH2);
        idle(34, pk(3'b000, 3'b000, 1'b1), M_CH2);
        idle(35, pk(3'b000, 3'b000, 1'b1), M_CH2);
        idle(36, pk(3'b000, 3'b000, 1'b1), M_CH2);
        idle(37, pk(3'b000, 3'b000, 1'b1), M_CH2);
        idle(38, pk(3'b100, 3'b000, 1'b1), M_CH2);
        step(39, 1'b1, 2'd2, 8'd32,  1'b0, pk(3'b000, 3'b100, 1'b1), M_CH2);
        step(40, 1'b1, 2'd2, 8'd16,  1'b0, pk(3'b000, 3'b100, 1'b1), M_CH2);
        step(41, 1'b1, 2'd3, 8'd255, 1'b0, pk(3'b000, 3'b100, 1'b1), M_CH2);
        idle(42, pk(3'b100, 3'b000, 1'b1), M_CH2);
        for (int k = 43; k < 58; k++) begin
            idle(k, pk(3'b000, 3'b000, 1'b1), M_CH2);
        end
        idle(58, pk(3'b100, 3'b000, 1'b1), M_CH2);

        // ch0 write coinciding with a transfer: old shadow applied, new one
        // stays pending until the following carry
        step(59, 1'b1, 2'd0, 8'd200, 1'b0, pk(3'b000, 3'b001, 1'b1), M_CH0);
        step(60, 1'b1, 2'd0, 8'd40,  1'b0, pk(3'b001, 3'b001, 1'b1), M_CH0);
        idle(61, pk(3'b000, 3'b001, 1'b1), M_CH0);
        idle(62, pk(3'b001, 3'b000, 1'b1), M_CH0);
        idle(63, pk(3'b000, 3'b000, 1'b1), M_CH0);
        idle(64, pk(3'b000, 3'b000, 1'b1), M_CH0);
        step(65, 1'b1, 2'd0, 8'd100, 1'b0, pk(3'b001, 3'b001, 1'b1), M_CH0);

        // Asynchronous reset while cen[0] and pending[0] are high
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cen",     OW'(cen),     OW'(0));
        chk("async_rst_pending", OW'(pending), OW'(0));
        chk("async_rst_ready",   OW'(ready),   OW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 101; k <= 105; k++) begin
            idle(k, pk(3'b000, 3'b000, 1'b0), M_ALL);
        end
        idle(106, pk(3'b000, 3'b000, 1'b1), M_ALL);
        step(107, 1'b1, 2'd0, 8'd64, 1'b0, pk(3'b000, 3'b001, 1'b1), M_ALL);
        step(108, 1'b1, 2'd1, 8'd32, 1'b0, pk(3'b000, 3'b010, 1'b1), M_ALL);
        idle(109, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(110, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(111, pk(3'b000, 3'b000, 1'b1), M_ALL);
`ifdef CEN_SYNC_EN
        // Realign on what would have been a ch0 carry: no pulse, then ch0
        // every 4th and ch1 on the 8th cycle, coincident with ch0
        step(112, 1'b0, 2'd0, 8'd0, 1'b1, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(113, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(114, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(115, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(116, pk(3'b001, 3'b000, 1'b1), M_ALL);
        idle(117, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(118, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(119, pk(3'b000, 3'b000, 1'b1), M_ALL);
        idle(120, pk(3'b011, 3'b000, 1'b1), M_ALL);
`else
        idle(112, pk(3'b001, 3'b000, 1'b1), M_ALL);
        idle(113, pk(3'b000, 3'b000, 1'b1), M_ALL);
`endif

        chk("scoreboard_drained", OW'(exp_q.size()), OW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
